// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO controllers.
// Contents: default address width, pointer-width helper, and Gray/binary conversion
// functions. The functions operate on 32-bit vectors; callers zero-extend narrower
// pointers and truncate the result, which works for any pointer width up to 32 bits.
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 3;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  binary equivalent (bin[i] = XOR of gray[WIDTH-1:i])
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller for the asynchronous FIFO.
// Keeps the binary and Gray write pointers, qualifies memory writes and produces a
// registered FULL flag from the synchronized Gray read pointer.
// Optional macro FIFO_LEVEL_EN adds registered FILL (occupancy) and AFULL outputs.
// Ports:
//   clk          in   write-domain clock
//   rst_n        in   asynchronous active-low reset
//   w_inc        in   write request
//   sync_rd_ptr  in   Gray read pointer synchronized into clk domain
//   w_en         out  memory write enable (w_inc & ~full), combinational
//   w_addr       out  memory write address (registered)
//   wr_ptr       out  registered Gray write pointer to the read domain
//   full         out  registered full flag
//   fill         out  registered occupancy estimate (FIFO_LEVEL_EN only)
//   afull        out  registered almost-full flag (FIFO_LEVEL_EN only)
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               w_inc,
  input  logic [ptr_width(ADDR_WIDTH)-1:0]   sync_rd_ptr,
  output logic                               w_en,
  output logic [ADDR_WIDTH-1:0]              w_addr,
  output logic [ptr_width(ADDR_WIDTH)-1:0]   wr_ptr,
`ifdef FIFO_LEVEL_EN
  output logic [ptr_width(ADDR_WIDTH)-1:0]   fill,
  output logic                               afull,
`endif
  output logic                               full
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);
  // Full when the write pointer leads the read pointer by exactly one lap: in Gray
  // code that is the read pointer with its two top bits inverted.
  localparam logic [PW-1:0] FullMask = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;

  assign w_en = w_inc & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + PW'(w_en);
    wgray_d = PW'(bin2gray(32'(wbin_d)));
    full_d  = (wgray_d == (sync_rd_ptr ^ FullMask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  assign w_addr = wbin_q[ADDR_WIDTH-1:0];
  assign wr_ptr = wgray_q;
  assign full   = full_q;

`ifdef FIFO_LEVEL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_q, fill_d;
  logic          afull_q, afull_d;

  gray_to_bin #(
    .WIDTH (PW)
  ) u_rd_g2b (
    .gray (sync_rd_ptr),
    .bin  (rbin)
  );

  always_comb begin
    fill_d  = wbin_d - rbin;
    afull_d = (32'(fill_d) >= AFULL_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      afull_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      afull_q <= afull_d;
    end
  end

  assign fill  = fill_q;
  assign afull = afull_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// The reference keeps plain integer counts of writes and reads; pointer, address,
// full and level expectations are derived from those counts.
module tb_fifo_wr_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LAP   = 1 << PW;
  localparam int unsigned THR   = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_inc;
  logic [PW-1:0] sync_rd_ptr;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [PW-1:0] wr_ptr;
  logic          full;
`ifdef FIFO_LEVEL_EN
  logic [PW-1:0] fill;
  logic          afull;
`endif

  fifo_wr_ctrl #(
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (THR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_inc       (w_inc),
    .sync_rd_ptr (sync_rd_ptr),
    .w_en        (w_en),
    .w_addr      (w_addr),
    .wr_ptr      (wr_ptr),
`ifdef FIFO_LEVEL_EN
    .fill        (fill),
    .afull       (afull),
`endif
    .full        (full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: total accepted writes, reads seen, registered full flag.
  int wr_cnt;
  int rd_cnt;
  bit full_m;

  function automatic logic [PW-1:0] gray_of(input int n);
    int m;
    m = n % LAP;
    return PW'(m ^ (m / 2));
  endfunction

  function automatic int occ(input int w, input int r);
    return (w - r) % LAP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wr_ptr"}, 32'(wr_ptr), 0);
    chk({tag, ".w_addr"}, 32'(w_addr), 0);
    chk({tag, ".full"}, 32'(full), 0);
`ifdef FIFO_LEVEL_EN
    chk({tag, ".fill"}, 32'(fill), 0);
    chk({tag, ".afull"}, 32'(afull), 0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin
      w_inc       = 1'($urandom);
      sync_rd_ptr = PW'($urandom);
      @(posedge clk);
      #1;
      chk_zero("reset");
    end
    w_inc       = 1'b0;
    sync_rd_ptr = '0;
    rst_n       = 1'b1;
    wr_cnt = 0;
    rd_cnt = 0;
    full_m = 1'b0;
  endtask

  // One clock: present inputs, check w_en, clock, update the reference, check outputs.
  task automatic step(input string tag, input bit w, input int rd);
    bit acc;
    w_inc       = w;
    rd_cnt      = rd;
    sync_rd_ptr = gray_of(rd);
    #1;
    chk({tag, ".w_en"}, 32'(w_en), 32'(w && !full_m));
    acc = w && !full_m;
    @(posedge clk);
    if (acc) wr_cnt++;
    full_m = (occ(wr_cnt, rd_cnt) == DEPTH);
    #1;
    chk({tag, ".wr_ptr"}, 32'(wr_ptr), 32'(gray_of(wr_cnt)));
    chk({tag, ".w_addr"}, 32'(w_addr), 32'(wr_cnt % DEPTH));
    chk({tag, ".full"}, 32'(full), 32'(full_m));
`ifdef FIFO_LEVEL_EN
    chk({tag, ".fill"}, 32'(fill), 32'(occ(wr_cnt, rd_cnt)));
    chk({tag, ".afull"}, 32'(afull), 32'(occ(wr_cnt, rd_cnt) >= THR));
`endif
  endtask

  initial begin
    logic [PW-1:0] prev;
    int rd;
    w_inc       = 1'b0;
    sync_rd_ptr = '0;
    rst_n       = 1'b0;
    #2;
    do_reset();

    // Fill from empty: eight writes then a refused ninth.
    for (int i = 0; i < 9; i++) step("fill", 1'b1, 0);
    chk("fill.ptr12", 32'(wr_ptr), 32'd12);
    chk("fill.full_set", 32'(full), 32'd1);

    // One read crosses the synchronizer: full drops without a write.
    step("drain", 1'b0, 1);
    chk("drain.full_clr", 32'(full), 32'd0);
    step("drain_wr", 1'b1, 1);
    chk("drain.ptr13", 32'(wr_ptr), 32'd13);

    // Wrap: reader trails two writes behind, gray changes one bit per write.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      prev = wr_ptr;
      step("wrap", 1'b1, (wr_cnt > 2) ? wr_cnt - 2 : 0);
      chk("wrap.onebit", 32'($countones(prev ^ wr_ptr)), 32'd1);
    end
    chk("wrap.ptr0", 32'(wr_ptr), 32'd0);
    chk("wrap.addr0", 32'(w_addr), 32'd0);

    // Asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 5; i++) step("mid", 1'b1, 0);
    chk("mid.ptr7", 32'(wr_ptr), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_async");
    @(negedge clk);
    rst_n  = 1'b1;
    wr_cnt = 0;
    full_m = 1'b0;
    step("mid_after", 1'b1, 0);
    chk("mid.ptr1", 32'(wr_ptr), 32'd1);

`ifdef FIFO_LEVEL_EN
    do_reset();
    for (int i = 0; i < 6; i++) step("lvl", 1'b1, 0);
    chk("lvl.fill6", 32'(fill), 32'd6);
    chk("lvl.afull1", 32'(afull), 32'd1);
    step("lvl_rd", 1'b0, 1);
    chk("lvl.fill5", 32'(fill), 32'd5);
    chk("lvl.afull0", 32'(afull), 32'd0);
`endif

    // Random traffic: reader advances monotonically and never passes the writer.
    do_reset();
    rd = 0;
    for (int i = 0; i < 300; i++) begin
      if (rd < wr_cnt && $urandom_range(0, 2) == 0) rd = rd + $urandom_range(1, wr_cnt - rd);
      step("rand", 1'($urandom_range(0, 3) != 0), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
